// File: rtl/pool_ppu_arb_pkg.sv
// Shared constants and FSM encoding for the pooling PPU input-lane arbiter.
package pool_ppu_arb_pkg;

  localparam int unsigned POOL_P       = 64;
  localparam int unsigned POOL_EW      = 14;
  localparam int unsigned POOL_BEATS   = 4;
  localparam int unsigned POOL_SLICE_W = (POOL_P / 2) * POOL_EW;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_WAIT,
    ST_SER,
    ST_FIN
  } arb_state_e;

endpackage

// File: rtl/pool_word_ser.sv
// Splits one 2P-element FIFO word into four registered P/2-element beats, low slice first.
module pool_word_ser
  import pool_ppu_arb_pkg::*;
#(
  parameter int unsigned P  = POOL_P,
  parameter int unsigned EW = POOL_EW
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_load,
  input  logic [2*P*EW-1:0]     i_word,
  input  logic                  i_src,
  output logic [(P/2)*EW-1:0]   o_beat,
  output logic                  o_vld,
  output logic                  o_src,
  output logic [1:0]            o_idx
);

  localparam int unsigned SW = (P / 2) * EW;
  localparam logic [1:0]  LAST_IDX = 2'(POOL_BEATS - 1);

  logic [2*P*EW-1:0] r_word;
  logic [SW-1:0]     r_beat;
  logic              r_vld;
  logic              r_src;
  logic [1:0]        r_idx;
  logic [SW-1:0]     w_next;

  // Slice shown after the one currently on the output.
  always_comb begin
    w_next = r_word[3*SW +: SW];
    case (r_idx)
      2'd0:    w_next = r_word[SW +: SW];
      2'd1:    w_next = r_word[2*SW +: SW];
      default: w_next = r_word[3*SW +: SW];
    endcase
  end

  // A load on the last beat continues straight into the next word.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_word <= '0;
      r_beat <= '0;
      r_vld  <= 1'b0;
      r_src  <= 1'b0;
      r_idx  <= 2'd0;
    end else if (i_load) begin
      r_word <= i_word;
      r_beat <= i_word[0 +: SW];
      r_vld  <= 1'b1;
      r_src  <= i_src;
      r_idx  <= 2'd0;
    end else if (r_vld && (r_idx != LAST_IDX)) begin
      r_beat <= w_next;
      r_idx  <= r_idx + 2'd1;
    end else begin
      r_beat <= '0;
      r_vld  <= 1'b0;
      r_src  <= 1'b0;
      r_idx  <= 2'd0;
    end
  end

  assign o_beat = r_beat;
  assign o_vld  = r_vld;
  assign o_src  = r_src;
  assign o_idx  = r_idx;

endmodule

// File: rtl/pool_ppu_arb.sv
// Round-robin sequencer sharing the pooling PPU lane between two PE-array output FIFOs.
module pool_ppu_arb
  import pool_ppu_arb_pkg::*;
#(
  parameter int unsigned P     = POOL_P,
  parameter int unsigned EW    = POOL_EW,
  parameter int unsigned CNT_W = 20
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [CNT_W-1:0]      total_words,
  output logic                  rd0_en,
  output logic                  rd1_en,
  input  logic [2*P*EW-1:0]     dout0,
  input  logic [2*P*EW-1:0]     dout1,
  input  logic                  dout0_vld,
  input  logic                  dout1_vld,
  input  logic                  empty0,
  input  logic                  empty1,
  output logic [(P/2)*EW-1:0]   ppus_Ys,
  output logic                  ppus_Ys_vld,
  output logic                  ppus_src,
  output logic                  busy,
  output logic                  done
);

  arb_state_e       r_state;
  logic [CNT_W-1:0] r_total;
  logic [CNT_W-1:0] r_granted;
  logic             r_ptr;
  logic             r_src_q;
  logic             r_rd0_en;
  logic             r_rd1_en;
  logic             r_busy;
  logic             r_done;

  logic             w_both;
  logic             w_any;
  logic             w_gnt_src;
  logic             w_more;
  logic             w_try;
  logic             w_grant;
  logic             w_load;
  logic [2*P*EW-1:0] w_load_word;
  logic             w_ser_vld;
  logic [1:0]       w_ser_idx;

  assign w_both      = ~empty0 & ~empty1;
  assign w_any       = ~empty0 | ~empty1;
  assign w_gnt_src   = w_both ? r_ptr : empty0;
  assign w_more      = r_granted < r_total;
  assign w_grant     = w_try & w_any;
  assign w_load      = (r_state == ST_WAIT) && (r_src_q ? dout1_vld : dout0_vld);
  assign w_load_word = r_src_q ? dout1 : dout0;

  // Decision points: start, retry after a stall, and the early read at beat index 1.
  always_comb begin
    w_try = 1'b0;
    case (r_state)
      ST_IDLE: w_try = start && !r_busy && (total_words != '0);
      ST_ARB:  w_try = w_more;
      ST_SER:  w_try = w_ser_vld && (w_ser_idx == 2'd1) && w_more;
      default: w_try = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_total   <= '0;
      r_granted <= '0;
      r_ptr     <= 1'b0;
      r_src_q   <= 1'b0;
      r_rd0_en  <= 1'b0;
      r_rd1_en  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_rd0_en <= 1'b0;
      r_rd1_en <= 1'b0;
      r_done   <= 1'b0;
      if (w_grant) begin
        r_rd0_en  <= ~w_gnt_src;
        r_rd1_en  <= w_gnt_src;
        r_src_q   <= w_gnt_src;
        r_granted <= r_granted + CNT_W'(1);
        if (w_both) r_ptr <= ~r_ptr;
      end
      case (r_state)
        ST_IDLE: begin
          if (start && !r_busy) begin
            r_total   <= total_words;
            r_granted <= w_grant ? CNT_W'(1) : '0;
            r_busy    <= 1'b1;
            if (total_words == '0) r_state <= ST_FIN;
            else if (w_grant)      r_state <= ST_WAIT;
            else                   r_state <= ST_ARB;
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_ARB: begin
          if (w_grant) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_load) r_state <= ST_SER;
        end
        ST_SER: begin
          // Finish from beat 2 of the last word so done lands right after beat 3.
          if (w_grant)                                   r_state <= ST_WAIT;
          else if (w_ser_vld && w_ser_idx == 2'd2 && !w_more) r_state <= ST_FIN;
          else if (w_ser_vld && w_ser_idx == 2'd3)       r_state <= ST_ARB;
        end
        ST_FIN: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  pool_word_ser #(
    .P  (P),
    .EW (EW)
  ) u_ser (
    .clk    (clk),
    .rstn   (rstn),
    .i_load (w_load),
    .i_word (w_load_word),
    .i_src  (r_src_q),
    .o_beat (ppus_Ys),
    .o_vld  (w_ser_vld),
    .o_src  (ppus_src),
    .o_idx  (w_ser_idx)
  );

  assign ppus_Ys_vld = w_ser_vld;
  assign rd0_en      = r_rd0_en;
  assign rd1_en      = r_rd1_en;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule
